// File: rtl/awg_ctrl_if.sv
// awg_ctrl_if: raw panel keys in, registered generator parameters out.
interface awg_ctrl_if;
   logic        key_mode_n;
   logic        key_sel_n;
   logic        key_up_n;
   logic        key_down_n;
   logic [2:0]  state;
   logic [11:0] state_freq;
   logic [2:0]  state_amp;
   logic [7:0]  state_phase;
   logic [1:0]  edit_sel;
   logic        upd;
   modport master (
      input  key_mode_n, key_sel_n, key_up_n, key_down_n,
      output state, state_freq, state_amp, state_phase, edit_sel, upd
   );
   modport slave (
      output key_mode_n, key_sel_n, key_up_n, key_down_n,
      input  state, state_freq, state_amp, state_phase, edit_sel, upd
   );
endinterface

// File: rtl/awg_ctrl.sv
// awg_ctrl: debounced front-panel keys driving waveform/frequency/amplitude/phase edits.
module awg_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int FREQ_STEP       = 1,
   parameter int FREQ_MAX        = 4095
) (
   input logic         clk,
   input logic         rst,
   awg_ctrl_if.master  bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
   localparam logic [2:0] S_SAW = 3'd0, S_TRI = 3'd1, S_SQR = 3'd2, S_SIN = 3'd3, S_NOISE = 3'd4, S_OFF = 3'd7;
   // key bit order: 0 mode, 1 sel, 2 up, 3 down; all levels held as 1 = pressed
   logic [3:0]    sync1, sync2, deb, deb_q, press;
   logic [DW-1:0] cnt [4];
   logic [RW-1:0] rcnt [2];
   logic [1:0]    ract, rep;
   logic          inc, dec;
   logic [1:0]    field, n_sel;
   logic [2:0]    n_state, n_amp;
   logic [11:0]   n_freq;
   logic [7:0]    n_phase;
   logic [12:0]   f_up, f_dn;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= ~{bus.key_down_n, bus.key_up_n, bus.key_sel_n, bus.key_mode_n};
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 4; i++)
            if (sync2[i] == deb[i]) cnt[i] <= '0;
            else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               cnt[i] <= '0;
               deb[i] <= ~deb[i];
            end else cnt[i] <= cnt[i] + 1'b1;
      end
   assign press  = deb & ~deb_q;
   assign rep[0] = deb[2] && rcnt[0] == (ract[0] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
   assign rep[1] = deb[3] && rcnt[1] == (ract[1] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
   // rcnt counts cycles since the press or the last repeat; 0 means idle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ract <= '0;
         for (int j = 0; j < 2; j++) rcnt[j] <= '0;
      end else
         for (int j = 0; j < 2; j++)
            if (!deb[j+2]) begin
               rcnt[j] <= '0;
               ract[j] <= 1'b0;
            end else if (press[j+2]) rcnt[j] <= RW'(1);
            else if (rep[j]) begin
               rcnt[j] <= RW'(1);
               ract[j] <= 1'b1;
            end else if (rcnt[j] != '0) rcnt[j] <= rcnt[j] + 1'b1;
   assign inc  = (press[2] | rep[0]) & ~(press[3] | rep[1]);
   assign dec  = (press[3] | rep[1]) & ~(press[2] | rep[0]);
   assign f_up = {1'b0, bus.state_freq} + 13'(FREQ_STEP);
   assign f_dn = {1'b0, bus.state_freq} - 13'(FREQ_STEP);
   always_comb begin
      field   = bus.edit_sel == 2'd3 ? 2'd0 : bus.edit_sel;
      n_state = !press[0] ? bus.state :
                bus.state == S_SAW ? S_TRI : bus.state == S_TRI ? S_SQR :
                bus.state == S_SQR ? S_SIN : bus.state == S_SIN ? S_NOISE :
                bus.state == S_NOISE ? S_OFF : S_SAW;
      n_sel   = !press[1] ? bus.edit_sel : field == 2'd2 ? 2'd0 : field + 2'd1;
      n_freq  = field != 2'd0 ? bus.state_freq :
                inc ? (f_up > 13'(FREQ_MAX) ? 12'(FREQ_MAX) : f_up[11:0]) :
                dec ? ((f_dn == '0 || f_dn[12]) ? 12'd1 : f_dn[11:0]) : bus.state_freq;
      n_amp   = field != 2'd1 ? bus.state_amp :
                inc && bus.state_amp != 3'd7 ? bus.state_amp + 3'd1 :
                dec && bus.state_amp != 3'd0 ? bus.state_amp - 3'd1 : bus.state_amp;
      n_phase = field != 2'd2 ? bus.state_phase :
                inc ? bus.state_phase + 8'd1 : dec ? bus.state_phase - 8'd1 : bus.state_phase;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.state       <= S_SAW;
         bus.state_freq  <= 12'd1;
         bus.state_amp   <= 3'd0;
         bus.state_phase <= 8'd0;
         bus.edit_sel    <= 2'd0;
         bus.upd         <= 1'b0;
      end else begin
         bus.state       <= n_state;
         bus.state_freq  <= n_freq;
         bus.state_amp   <= n_amp;
         bus.state_phase <= n_phase;
         bus.edit_sel    <= n_sel;
         bus.upd         <= n_state != bus.state || n_freq != bus.state_freq ||
                            n_amp != bus.state_amp || n_phase != bus.state_phase;
      end
endmodule
